// File: rtl/snoop_arbiter.sv
// Round-robin snoop bus arbiter: issues a one-cycle grant, then holds bus ownership
// until the owner signals done or the watchdog releases the bus.
module snoop_arbiter #(
    parameter int NUM_CACHE = 4,
    parameter int NUM_NODES = NUM_CACHE,
    parameter int MAX_HOLD  = 64,
    localparam int IW = $clog2(NUM_NODES),
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_NODES-1:0] req,
    input  logic [NUM_NODES-1:0] done,
    output logic [NUM_NODES-1:0] gnt,
    output logic [IW-1:0]        owner,
    output logic                 owner_valid,
    output logic                 timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [CW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [NUM_NODES-1:0] gnt_q;
    logic                 owner_done, at_limit, rel;
    logic [IW-1:0]        rel_ptr;

    // First requester at or after p, wrapping explicitly for non-power-of-2 counts.
    function automatic logic [IW-1:0] pick(input logic [NUM_NODES-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < NUM_NODES; k++) begin
            idx = int'(p) + k;
            if (idx >= NUM_NODES) idx = idx - NUM_NODES;
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = IW'(idx);
            end
        end
        return w;
    endfunction

    assign owner_done = done[owner_q];
    assign at_limit   = (MAX_HOLD > 0) && (hold_cnt_q == CW'(MAX_HOLD - 1));
    assign rel        = (state_q == BUSY) && (owner_done || at_limit);
    assign rel_ptr    = (owner_q == IW'(NUM_NODES - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= (state_d == GRANT) ? (NUM_NODES'(1) << owner_d) : '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = '0;
        case (state_q)
            IDLE: if (|req) begin
                owner_d = pick(req, ptr_q);
                state_d = GRANT;
            end
            GRANT: state_d = BUSY;
            BUSY: begin
                if (rel) begin
                    ptr_d = rel_ptr;
                    if (|req) begin
                        owner_d = pick(req, rel_ptr);
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD > 0) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt         = gnt_q;
        owner       = owner_q;
        owner_valid = (state_q != IDLE);
        // done on the limit cycle wins over the watchdog; reset abandons without a pulse
        timeout     = (state_q == BUSY) && at_limit && !owner_done && !rst;
    end

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_pulse:   assert property (@(posedge clk) disable iff (rst) (|gnt) |=> (gnt == '0));
    a_to_busy:     assert property (@(posedge clk) disable iff (rst) timeout |-> (state_q == BUSY));
    c_fast_path:   cover property (@(posedge clk) disable iff (rst) rel && (state_d == GRANT));
    c_timeout:     cover property (@(posedge clk) disable iff (rst) timeout);
    c_done_limit:  cover property (@(posedge clk) disable iff (rst) (state_q == BUSY) && at_limit && owner_done);
    for (genvar i = 0; i < NUM_NODES; i++) begin : g_cov
        c_gnt: cover property (@(posedge clk) disable iff (rst) gnt[i]);
    end
`endif

endmodule

// File: tb/tb_snoop_arbiter.sv
// Directed bench for snoop_arbiter with NUM_NODES=4, MAX_HOLD=4.
module tb_snoop_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, done, gnt;
    logic [1:0] owner;
    logic       owner_valid, timeout;
    int         total = 0;
    int         bad   = 0;

    snoop_arbiter #(.NUM_NODES(4), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt),
        .owner(owner), .owner_valid(owner_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; done = '0;
        cyc(); cyc();
        chk("rst_gnt", gnt, 0); chk("rst_owner", owner, 0);
        chk("rst_ov", owner_valid, 0); chk("rst_to", timeout, 0);
        rst = 1'b0;
        cyc();

        // all four request: rotation 0,1,2,3,0 with back-to-back grants
        req = 4'b1111; #1;
        chk("rr_idle_gnt", gnt, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(); done = '0;
            if (k == 4) req = '0;
            #1;
            chk($sformatf("rr_gnt%0d", k), gnt, 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr_own%0d", k), owner, k % 4);
            cyc(); #1;
            chk($sformatf("rr_busy%0d", k), gnt, 0);
            cyc(); done = 4'b0001 << (k % 4); #1;
            chk($sformatf("rr_to%0d", k), timeout, 0);
        end
        cyc(); done = '0; #1;
        chk("rr_end_ov", owner_valid, 0);

        // lone request from node 2 (ptr now 1)
        req = 4'b0100; #1;
        chk("t1_idle", gnt, 0);
        cyc(); req = '0; #1;
        chk("t1_gnt", gnt, 4'b0100); chk("t1_own", owner, 2); chk("t1_ov", owner_valid, 1);
        cyc(); #1;
        chk("t1_gnt_off", gnt, 0); chk("t1_ov_busy", owner_valid, 1);
        done = 4'b0100;
        cyc(); done = '0; #1;
        chk("t1_released", owner_valid, 0);

        // ptr=3 with req 1001: node 3 first, then wrap to node 0
        req = 4'b1001;
        cyc(); #1;
        chk("wrap_gnt3", gnt, 4'b1000); chk("wrap_own3", owner, 3);
        req = 4'b0001;
        cyc(); done = 4'b1000;
        cyc(); done = '0; #1;
        chk("wrap_gnt0", gnt, 4'b0001); chk("wrap_own0", owner, 0);
        req = '0;
        cyc(); done = 4'b0001;
        cyc(); done = '0; #1;
        chk("wrap_idle", owner_valid, 0);

        // watchdog, with a non-owner done in the middle (ptr=1)
        req = 4'b0011;
        cyc(); #1;
        chk("wd_gnt", gnt, 4'b0010); chk("wd_own", owner, 1);
        req = 4'b0001;
        cyc(); #1; chk("wd_b1_to", timeout, 0);
        cyc(); done = 4'b0001; #1; chk("wd_b2_to", timeout, 0);
        cyc(); done = '0; #1;
        chk("wd_nonowner_ov", owner_valid, 1); chk("wd_nonowner_own", owner, 1);
        chk("wd_b3_to", timeout, 0);
        cyc(); #1; chk("wd_b4_to", timeout, 1);
        cyc(); #1;
        chk("wd_next_gnt", gnt, 4'b0001); chk("wd_next_own", owner, 0); chk("wd_to_off", timeout, 0);
        req = '0;
        cyc(); cyc(); cyc();
        cyc(); done = 4'b0001; #1;
        chk("lim_done_to", timeout, 0);
        cyc(); done = '0; #1;
        chk("lim_done_rel", owner_valid, 0);

        // reset in BUSY with node 1 pending
        req = 4'b0010;
        cyc(); #1; chk("rb_gnt", gnt, 4'b0010);
        cyc(); rst = 1'b1; #1;
        chk("rb_to", timeout, 0);
        cyc(); #1;
        chk("rb_gnt0", gnt, 0); chk("rb_ov0", owner_valid, 0);
        chk("rb_own0", owner, 0); chk("rb_to0", timeout, 0);
        rst = 1'b0;
        cyc(); #1;
        chk("rb_regnt", gnt, 4'b0010); chk("rb_reown", owner, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
